acc_cpu_core: RTL and testbench

Parametrised accumulator CPU core and successor to the fixed 8-bit CPU. It executes 8-bit instructions against an accumulator `C` and a register file of `REG_CNT` registers, each `DATA_W` wide. It adds a valid/ready instruction handshake, status flags, an illegal-opcode pulse, a debug read port and an optional multi-cycle multiplier. The instruction source, a bench or a fetch unit, drives it directly.

---
 rtl/acc_cpu_pkg.sv | 29 ++
 rtl/acc_cpu_if.sv | 26 ++
 rtl/acc_cpu_mul.sv | 59 +++++
 rtl/acc_cpu_core.sv | 158 +++++++++++++++
 tb/tb_acc_cpu_core.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core: opcodes, instruction field
// positions and the sequencing FSM state type.
package acc_cpu_pkg;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_NOT = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 4;
    localparam int OPR_HI  = 3;
    localparam int OPR_LO  = 0;
    localparam int DIR_BIT = 3;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_RUN
    } state_e;

endpackage

// File: rtl/acc_cpu_if.sv
// Instruction handshake, status and debug-read bundle between an instruction
// source (master) and acc_cpu_core (slave).
interface acc_cpu_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic              zero;
    logic              busy;
    logic              illegal;
    logic [2:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output inst, inst_valid, dbg_sel,
        input  inst_ready, acc, carry, zero, busy, illegal, dbg_data
    );

    modport slave (
        input  inst, inst_valid, dbg_sel,
        output inst_ready, acc, carry, zero, busy, illegal, dbg_data
    );
endinterface

// File: rtl/acc_cpu_mul.sv
// Iterative shift-add multiplier, one partial product per cycle over DATA_W cycles.
// done/result are combinational so the owner can capture the product on the final edge.
module acc_cpu_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = CW'(DATA_W);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Last iteration is folded into the output so the product lands on edge T+DATA_W.
    assign done   = (cnt_q == CW'(1));
    assign result = prod_d;

endmodule

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core with valid/ready instruction handshake.
// Define ACC_CPU_MUL_EN to enable the multi-cycle MUL (0xA); otherwise 0xA is illegal.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8
) (
    input  logic     clk,
    input  logic     rst,
    acc_cpu_if.slave bus
);
    localparam int RW = $clog2(REG_CNT);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   c_q, c_d;
    logic [DATA_W-1:0]   regs_q [REG_CNT];
    logic [DATA_W-1:0]   regs_d [REG_CNT];
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                c_we;
    logic                accept;
    logic [3:0]          opc;
    logic [RW-1:0]       n;
    logic [DATA_W-1:0]   r_n;
    logic [DATA_W:0]     add_res;
    logic [DATA_W:0]     sub_res;
    logic                unused_dbg_sel;

    assign opc     = bus.inst[OPC_HI:OPC_LO];
    assign n       = bus.inst[RW-1:0];
    assign r_n     = regs_q[n];
    assign accept  = bus.inst_valid & ready_q;
    assign add_res = {1'b0, c_q} + {1'b0, r_n};
    assign sub_res = {1'b0, c_q} - {1'b0, r_n};

`ifdef ACC_CPU_MUL_EN
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_res;

    acc_cpu_mul #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .rst_n  (rst),
        .start  (mul_start),
        .a      (c_q),
        .b      (r_n),
        .done   (mul_done),
        .result (mul_res)
    );
`endif

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        regs_d    = regs_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        illegal_d = 1'b0;
        busy_d    = busy_q;
        ready_d   = ready_q;
        c_we      = 1'b0;
`ifdef ACC_CPU_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (opc)
                        OP_MOV: begin
                            if (bus.inst[DIR_BIT]) begin
                                regs_d[n] = c_q;
                            end else begin
                                c_d  = r_n;
                                c_we = 1'b1;
                            end
                        end
                        OP_LDI: begin c_d = DATA_W'(bus.inst[OPR_HI:OPR_LO]); c_we = 1'b1; end
                        OP_ADD: begin {carry_d, c_d} = add_res; c_we = 1'b1; end
                        OP_NOT: begin c_d = ~r_n; c_we = 1'b1; end
                        OP_AND: begin c_d = c_q & r_n; c_we = 1'b1; end
                        OP_OR:  begin c_d = c_q | r_n; c_we = 1'b1; end
                        OP_XOR: begin c_d = c_q ^ r_n; c_we = 1'b1; end
                        OP_SUB: begin {carry_d, c_d} = sub_res; c_we = 1'b1; end
                        OP_SHL: begin carry_d = c_q[DATA_W-1]; c_d = c_q << 1; c_we = 1'b1; end
                        OP_SHR: begin carry_d = c_q[0]; c_d = c_q >> 1; c_we = 1'b1; end
                        OP_MUL: begin
`ifdef ACC_CPU_MUL_EN
                            mul_start = 1'b1;
                            state_d   = ST_MUL_RUN;
                            busy_d    = 1'b1;
                            ready_d   = 1'b0;
`else
                            illegal_d = 1'b1;
`endif
                        end
                        OP_NOP: ;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_MUL_RUN: begin
`ifdef ACC_CPU_MUL_EN
                if (mul_done) begin
                    c_d     = mul_res[DATA_W-1:0];
                    carry_d = |mul_res[2*DATA_W-1:DATA_W];
                    c_we    = 1'b1;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // zero tracks C only when C is written; the reset value is deliberately 0.
        if (c_we) begin
            zero_d = (c_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            regs_q    <= '{default: '0};
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            regs_q    <= regs_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.inst_ready = ready_q;
    assign bus.acc        = c_q;
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;
    assign bus.busy       = busy_q;
    assign bus.illegal    = illegal_q;
    assign bus.dbg_data   = regs_q[bus.dbg_sel[RW-1:0]];
    assign unused_dbg_sel = ^bus.dbg_sel;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core (8-bit/8-reg instance plus a 16-bit/4-reg instance).
// Honours ACC_CPU_MUL_EN to select the expected MUL behaviour.
module tb_acc_cpu_core;

`ifdef ACC_CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] inst;
        logic [7:0] acc;
        logic       carry;
        logic       zero;
        logic       ill;
        bit         chk_reg;
        logic [2:0] sel;
        logic [7:0] rv;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    bit          pend;
    bit          prev_busy;
    int unsigned busy_cnt;

    acc_cpu_if #(.DATA_W(8))  bus ();
    acc_cpu_if #(.DATA_W(16)) bus2 ();

    acc_cpu_core #(.DATA_W(8), .REG_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    acc_cpu_core #(.DATA_W(16), .REG_CNT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic issue(input logic [7:0] i, input logic [7:0] a, input logic c, input logic z,
                         input logic il, input bit cr, input logic [2:0] s, input logic [7:0] rv,
                         input bit push);
        exp_t        e;
        int unsigned waited;
        e = '{inst: i, acc: a, carry: c, zero: z, ill: il, chk_reg: cr, sel: s, rv: rv};
        if (push) exp_q.push_back(e);
        bus.inst       = i;
        bus.inst_valid = 1'b1;
        waited         = 0;
        @(negedge clk);
        while (!bus.inst_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.inst_ready) begin
            chk($sformatf("accept_timeout@%02h", i), 32'(bus.inst_ready), 32'd1);
            if (push) void'(exp_q.pop_back());
            bus.inst_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.inst_valid = 1'b0;
        end
    endtask

    task automatic op(input logic [7:0] i, input logic [7:0] a, input logic c, input logic z, input logic il);
        issue(i, a, c, z, il, 1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    task automatic st(input logic [7:0] i, input logic [7:0] a, input logic c, input logic z,
                      input logic [2:0] s, input logic [7:0] rv);
        issue(i, a, c, z, 1'b0, 1'b1, s, rv, 1'b1);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        bus.dbg_sel = e.sel;
        #1;
        chk($sformatf("acc@%02h", e.inst),     32'(bus.acc),        32'(e.acc));
        chk($sformatf("carry@%02h", e.inst),   32'(bus.carry),      32'(e.carry));
        chk($sformatf("zero@%02h", e.inst),    32'(bus.zero),       32'(e.zero));
        chk($sformatf("illegal@%02h", e.inst), 32'(bus.illegal),    32'(e.ill));
        chk($sformatf("ready@%02h", e.inst),   32'(bus.inst_ready), 32'd1);
        chk($sformatf("busy@%02h", e.inst),    32'(bus.busy),       32'd0);
        if (e.chk_reg) chk($sformatf("r%0d@%02h", e.sel, e.inst), 32'(bus.dbg_data), 32'(e.rv));
    endtask

    // Monitor: one result is due the cycle after a single-cycle accept, or when busy falls.
    initial begin
        pend        = 1'b0;
        prev_busy   = 1'b0;
        busy_cnt    = 0;
        bus.dbg_sel = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend      = 1'b0;
                prev_busy = 1'b0;
                busy_cnt  = 0;
            end else begin
                if (bus.busy) begin
                    busy_cnt++;
                    chk("ready_while_busy", 32'(bus.inst_ready), 32'd0);
                end
                if (prev_busy && !bus.busy) chk("busy_cycles", busy_cnt, 32'd8);
                if (pend || (prev_busy && !bus.busy)) pop_check();
                if (!bus.busy) busy_cnt = 0;
                prev_busy = bus.busy;
                pend = bus.inst_valid && bus.inst_ready && !(MUL_EN && bus.inst[7:4] == 4'hA);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_acc"},     32'(bus.acc),        32'd0);
        chk({tag, "_carry"},   32'(bus.carry),      32'd0);
        chk({tag, "_zero"},    32'(bus.zero),       32'd0);
        chk({tag, "_busy"},    32'(bus.busy),       32'd0);
        chk({tag, "_illegal"}, 32'(bus.illegal),    32'd0);
        chk({tag, "_ready"},   32'(bus.inst_ready), 32'd1);
    endtask

    task automatic drain(input string tag);
        int unsigned w;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] v16 [3];
        checks = 0;
        errors = 0;
        rst             = 1'b0;
        bus.inst        = 8'h00;
        bus.inst_valid  = 1'b0;
        bus2.inst       = 8'h00;
        bus2.inst_valid = 1'b0;
        bus2.dbg_sel    = 3'd7;
        #12;
        check_reset_values("por");
        @(negedge clk);
        #2 rst = 1'b1;

        // Legacy program, one instruction per cycle
        op(8'h15, 8'h05, 0, 0, 0);
        st(8'h08, 8'h05, 0, 0, 3'd0, 8'h05);
        op(8'h00, 8'h05, 0, 0, 0);
        st(8'h09, 8'h05, 0, 0, 3'd1, 8'h05);
        op(8'h31, 8'hFA, 0, 0, 0);
        st(8'h0A, 8'hFA, 0, 0, 3'd2, 8'hFA);

        // r3 = 0x20, C = 0xF0, then ADD wrap and SUB equal
        op(8'h12, 8'h02, 0, 0, 0);
        op(8'h80, 8'h04, 0, 0, 0);
        op(8'h80, 8'h08, 0, 0, 0);
        op(8'h80, 8'h10, 0, 0, 0);
        op(8'h80, 8'h20, 0, 0, 0);
        st(8'h0B, 8'h20, 0, 0, 3'd3, 8'h20);
        op(8'h1F, 8'h0F, 0, 0, 0);
        op(8'h80, 8'h1E, 0, 0, 0);
        op(8'h80, 8'h3C, 0, 0, 0);
        op(8'h80, 8'h78, 0, 0, 0);
        op(8'h80, 8'hF0, 0, 0, 0);
        op(8'h23, 8'h10, 1, 0, 0);
        op(8'h03, 8'h20, 1, 0, 0);
        op(8'h73, 8'h00, 0, 1, 0);

        // SHR out of bit 0, logic ops leave carry alone
        op(8'h11, 8'h01, 0, 0, 0);
        op(8'h90, 8'h00, 1, 1, 0);
        op(8'h52, 8'hFA, 1, 0, 0);
        op(8'h62, 8'h00, 1, 1, 0);
        op(8'h31, 8'hFA, 1, 0, 0);
        op(8'h40, 8'h00, 1, 1, 0);

        // Undefined opcode, then NOP shows the pulse was a single cycle
        op(8'hC0, 8'h00, 1, 1, 1);
        op(8'hF0, 8'h00, 1, 1, 0);

        // MUL 12 * 11 with a held LDI behind it
        op(8'h1B, 8'h0B, 1, 0, 0);
        st(8'h09, 8'h0B, 1, 0, 3'd1, 8'h0B);
        op(8'h1C, 8'h0C, 1, 0, 0);
        if (MUL_EN) begin
            op(8'hA1, 8'h84, 0, 0, 0);
            op(8'h15, 8'h05, 0, 0, 0);
        end else begin
            op(8'hA1, 8'h0C, 1, 0, 1);
            op(8'h15, 8'h05, 1, 0, 0);
        end
        drain("main");

        // Reset, mid-MUL when the multiplier is built in
        if (MUL_EN) begin
            issue(8'hA1, 8'h00, 0, 0, 0, 1'b0, 3'd0, 8'h00, 1'b0);
            repeat (3) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        #1 rst = 1'b0;
        #1 check_reset_values("rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("ready_after_release", 32'(bus.inst_ready), 32'd1);
        st(8'h00, 8'h00, 0, 1, 3'd1, 8'h00);
        drain("post_rst");

        // 16-bit, 4-register instance
        v16 = '{8'h1F, 8'h0F, 8'h80};
        for (int k = 0; k < 3; k++) begin
            bus2.inst       = v16[k];
            bus2.inst_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("w16_ready%0d", k), 32'(bus2.inst_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        bus2.inst_valid = 1'b0;
        @(negedge clk);
        chk("w16_acc",   32'(bus2.acc),      32'h001E);
        chk("w16_carry", 32'(bus2.carry),    32'd0);
        chk("w16_zero",  32'(bus2.zero),     32'd0);
        chk("w16_dbg7",  32'(bus2.dbg_data), 32'h000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
